// File: rtl/seg7_display_ctrl.sv
// Multi-digit seven-segment display controller: holding registers, glyph decode, blink and
// registered active-low segment outputs. Define SEG7_LZB_EN to add leading-zero blanking.
module seg7_display_ctrl #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [5*NUM_DIGITS-1:0] codes,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    blink_phase
);

  localparam int             CNT_W   = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);
  localparam logic [4:0]     CODE_BLANK = 5'h17;

  logic [5*NUM_DIGITS-1:0] code_q;
  logic [NUM_DIGITS-1:0]   mask_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    phase_q;
  logic                    armed_q;
  logic [7*NUM_DIGITS-1:0] seg_d;
  logic [6:0]              digit;
`ifdef SEG7_LZB_EN
  logic                    leading;
`endif

  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] g;
    case (code)
      5'h00: g = 7'b1000000;
      5'h01: g = 7'b1111001;
      5'h02: g = 7'b0100100;
      5'h03: g = 7'b0110000;
      5'h04: g = 7'b0011001;
      5'h05: g = 7'b0010010;
      5'h06: g = 7'b0000010;
      5'h07: g = 7'b1111000;
      5'h08: g = 7'b0000000;
      5'h09: g = 7'b0011000;
      5'h0A: g = 7'b0001000;
      5'h0B: g = 7'b0000011;
      5'h0C: g = 7'b1000110;
      5'h0D: g = 7'b0100001;
      5'h0E: g = 7'b0000110;
      5'h0F: g = 7'b0001110;
      5'h10: g = 7'b0001111;
      5'h11: g = 7'b1001011;
      5'h12: g = 7'b0101111;
      5'h17: g = 7'b1111111;
      5'h1B: g = 7'b0010000;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  // The blink counter stays idle after reset until the first load, so outputs hold reset values.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking (<=) so every register samples pre-edge values.
    if (rst) begin
      code_q  <= {NUM_DIGITS{CODE_BLANK}};
      mask_q  <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      armed_q <= 1'b0;
    end else if (load) begin
      code_q  <= codes;
      mask_q  <= blink_mask;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      armed_q <= 1'b1;
    end else if (armed_q) begin
      if (cnt_q == CNT_MAX) begin
        cnt_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    seg_d = '1;
    digit = '1;
`ifdef SEG7_LZB_EN
    leading = 1'b1;
`endif
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      digit = decode(code_q[5*i +: 5]);
`ifdef SEG7_LZB_EN
      if (code_q[5*i +: 5] != 5'h00) leading = 1'b0;
      if (leading && (i != 0)) digit = 7'h7F;
`endif
      if (phase_q && mask_q[i]) digit = 7'h7F;
      seg_d[7*i +: 7] = digit;
    end
  end

  // Segment and phase outputs share one register stage so they change on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg         <= '1;
      blink_phase <= 1'b0;
    end else begin
      seg         <= seg_d;
      blink_phase <= phase_q;
    end
  end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Self-checking bench for seg7_display_ctrl (NUM_DIGITS=6, BLINK_DIV=4): table vectors plus
// blink, load-on-wrap and reset sequences, compared through a cycle-tagged scoreboard.
module tb_seg7_display_ctrl;

  localparam int ND  = 6;
  localparam int DIV = 4;
  localparam logic [41:0] DARK = {42{1'b1}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load = 1'b0;
  logic [29:0]   codes = '0;
  logic [5:0]    blink_mask = '0;
  logic [41:0]   seg;
  logic          blink_phase;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          due;
    logic [41:0] seg;
    logic        ph;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [29:0] codes;
    logic [5:0]  mask;
    logic [41:0] seg;
  } vec_t;
  vec_t vec[7];

  seg7_display_ctrl #(.NUM_DIGITS(ND), .BLINK_DIV(DIV)) dut (
    .clk(clk), .rst(rst), .load(load), .codes(codes),
    .blink_mask(blink_mask), .seg(seg), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [41:0] apply_blink(input logic [41:0] s, input logic [5:0] m,
                                              input logic ph);
    logic [41:0] r;
    r = s;
    for (int i = 0; i < ND; i++)
      if (ph && m[i]) r[7*i +: 7] = 7'h7F;
    return r;
  endfunction

  // Scoreboard monitor: compares each expected entry on the cycle it falls due.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("sb_due", 64'(e.due), 64'(cyc));
      check("sb_seg", 64'(seg), 64'(e.seg));
      check("sb_phase", 64'(blink_phase), 64'(e.ph));
    end
  end

  // Drive one load and expect n output cycles; phase flips every DIV cycles of output.
  task automatic load_run(input logic [29:0] c, input logic [5:0] m, input logic [41:0] s,
                          input int n);
    int base;
    base = cyc;
    codes = c;
    blink_mask = m;
    load = 1'b1;
    for (int k = 1; k <= n; k++) begin
      logic ph;
      ph = 1'(((k - 1) / DIV) % 2);
      sb.push_back('{due: base + 1 + k, seg: apply_blink(s, m, ph), ph: ph});
    end
    @(negedge clk);
    load = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    logic [29:0] blink_codes;
    logic [41:0] blink_seg;

    vec[0] = '{{5'h12, 5'h1B, 5'h11, 5'h10, 5'h17, 5'h1F}, 6'b0,
               {7'b0101111, 7'b0010000, 7'b1001011, 7'b0001111, 7'b1111111, 7'b0000000}};
    vec[1] = '{{5'h05, 5'h04, 5'h03, 5'h02, 5'h01, 5'h00}, 6'b0,
               {7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000}};
    vec[2] = '{{5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0E, 5'h0F}, 6'b0,
               {7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110}};
    vec[3] = '{{5'h06, 5'h07, 5'h08, 5'h09, 5'h13, 5'h18}, 6'b0,
               {7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000, 7'b0000000, 7'b0000000}};
    vec[4] = '{{5'h17, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}, 6'b0,
               {7'b1111111, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
`ifdef SEG7_LZB_EN
    vec[5] = '{{5'h00, 5'h00, 5'h07, 5'h00, 5'h00, 5'h03}, 6'b0,
               {7'b1111111, 7'b1111111, 7'b1111000, 7'b1000000, 7'b1000000, 7'b0110000}};
    vec[6] = '{{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}, 6'b0,
               {7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111, 7'b1000000}};
`else
    vec[5] = '{{5'h00, 5'h00, 5'h07, 5'h00, 5'h00, 5'h03}, 6'b0,
               {7'b1000000, 7'b1000000, 7'b1111000, 7'b1000000, 7'b1000000, 7'b0110000}};
    vec[6] = '{{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00}, 6'b0,
               {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
`endif
    blink_codes = {5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h08};
    blink_seg   = {7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001, 7'b1111001, 7'b0000000};

    // Reset held for 3 cycles, then 10 idle cycles with no load.
    repeat (3) begin
      @(negedge clk);
      check("rst_seg", 64'(seg), 64'(DARK));
      check("rst_phase", 64'(blink_phase), 64'd0);
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_seg", 64'(seg), 64'(DARK));
      check("idle_phase", 64'(blink_phase), 64'd0);
    end

    // Table vectors loaded back to back: each shows for exactly one cycle, last one wins.
    for (int i = 0; i < 7; i++) load_run(vec[i].codes, vec[i].mask, vec[i].seg, 1);
    // Isolated load: content is retained while load stays low.
    load_run(vec[0].codes, vec[0].mask, vec[0].seg, 3);

    // Digit 0 blinks; second load lands on the wrap edge and must restart lit.
    load_run(blink_codes, 6'b000001, blink_seg, DIV);
    load_run(blink_codes, 6'b000001, blink_seg, 3 * DIV);

    // Zero mask: counter runs but seg stays steady.
    load_run(vec[1].codes, 6'b0, vec[1].seg, 2 * DIV + 1);

    // All digits blinking, reset while dark, together with a load of visible codes.
    load_run(blink_codes, 6'b111111, blink_seg, DIV + 2);
    @(negedge clk);
    begin
      int base;
      base = cyc;
      rst = 1'b1;
      load = 1'b1;
      codes = vec[2].codes;
      blink_mask = 6'b111111;
      for (int k = 1; k <= 8; k++) sb.push_back('{due: base + k, seg: DARK, ph: 1'b0});
      @(negedge clk);
      rst = 1'b0;
      load = 1'b0;
      repeat (9) @(negedge clk);
    end

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
